// File: rtl/alu_seq_if.sv
// alu_seq_if: command/result bundle for alu_seq.
//
// Signals
//   in_valid / in_ready    command handshake (producer -> ALU)
//   x, y                   WIDTH-bit operands
//   zx nx zy ny f no       Hack control bits
//   mode                   0 Hack, 1 multiply, 2 shift left, 3 shift right
//   out, zr, ng            registered result and its flags
//   out_valid / out_ready  result handshake (ALU -> consumer)
//
// Modports
//   master  the CPU side: drives commands, consumes results
//   slave   the ALU side
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
    input  in_ready, out, zr, ng, out_valid
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
    output in_ready, out, zr, ng, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle successor to the Hack ALU.
//
// Keeps the six Hack control bits for operand preprocessing and the final
// inversion, and adds a mode field: 0 = Hack ALU, 1 = iterative multiply,
// 2 = shift left logical, 3 = shift right logical. Commands are accepted
// in IDLE only; single-cycle modes go straight to DONE, multiply spends
// exactly WIDTH cycles in MUL. The result is held in DONE until consumed.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   alu_seq_if.slave -- command and result handshakes
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] out_q;
  logic             zr_q;
  logic             ng_q;

  logic [WIDTH-1:0] px;
  logic [WIDTH-1:0] py;
  logic [WIDTH-1:0] r_core;
  logic [WIDTH-1:0] direct_res;

  // Multiplier datapath
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             mul_no;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mul_res;

  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic             load_res;
  logic [WIDTH-1:0] load_val;

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign is_mul   = (bus.mode == 2'd1);
  assign mul_last = (state == ST_MUL) && (count == LAST_ITER);

  // Operand preprocessing and single-cycle result, shared by every mode.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    px = bus.zx ? '0 : bus.x;
    if (bus.nx) px = ~px;
    py = bus.zy ? '0 : bus.y;
    if (bus.ny) py = ~py;

    r_core = '0;
    case (bus.mode)
      2'd0:    r_core = bus.f ? (px + py) : (px & py);
      // Only the low SHW bits steer the shifter; anything at or beyond
      // WIDTH is caught by the range check and forced to zero.
      2'd2:    r_core = (py >= WIDTH_V) ? '0 : (px << py[SHW-1:0]);
      2'd3:    r_core = (py >= WIDTH_V) ? '0 : (px >> py[SHW-1:0]);
      default: r_core = '0;  // multiply result comes from the MUL path
    endcase

    direct_res = bus.no ? ~r_core : r_core;
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_res  = mul_no ? ~acc_next : acc_next;

  // Single point where out/zr/ng are loaded: a direct-mode accept or the
  // final multiply iteration.
  assign load_res = (accept && !is_mul) || mul_last;
  assign load_val = mul_last ? mul_res : direct_res;

  // Control state and registered result.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      out_q <= '0;
      zr_q  <= 1'b1;
      ng_q  <= 1'b0;
    end else begin
      if (load_res) begin
        out_q <= load_val;
        zr_q  <= (load_val == '0);
        ng_q  <= load_val[WIDTH-1];
      end

      case (state)
        ST_IDLE: begin
          if (accept) state <= is_mul ? ST_MUL : ST_DONE;
        end
        ST_MUL: begin
          if (mul_last) state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift-and-add multiplier. Always runs WIDTH iterations so latency is
  // independent of the operands.
  // NOTE: these datapath registers carry no reset; they are always loaded on
  // accept before MUL reads them, and a reset simply abandons their contents.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand  <= px;
      mplier <= py;
      mul_no <= bus.no;
      acc    <= '0;
      count  <= '0;
    end else if (state == ST_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH = 16).
// Inputs change on the falling edge; outputs are sampled 1 time unit
// after the rising edge.
module tb_alu_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] mode, input logic [5:0] ctrl,
                           input logic [W-1:0] x, input logic [W-1:0] y);
    bus.mode = mode;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctrl;
    bus.x = x;
    bus.y = y;
    bus.in_valid = 1'b1;
  endtask

  // Issue one command from IDLE, measure latency, check the result and
  // flags, then consume it and check the return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [5:0] ctrl,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    drive_cmd(mode, ctrl, x, y);
    @(posedge clk);  // accept edge
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " out"}, 32'(bus.out), 32'(exp));
    check({tag, " zr"}, 32'(bus.zr), 32'(exp == '0));
    check({tag, " ng"}, 32'(bus.ng), 32'(exp[W-1]));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " consumed valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " consumed ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_cmd(2'd0, 6'b000000, '0, '0);
    bus.in_valid  = 1'b0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("por out", 32'(bus.out), 32'd0);
    check("por zr", 32'(bus.zr), 32'd1);
    check("por in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("por release in_ready", 32'(bus.in_ready), 32'd1);

    // Mode 0, Hack ops
    run_op("x-y",   2'd0, 6'b010011, 16'd100, 16'd3, 16'd97,   1);
    run_op("y-x",   2'd0, 6'b000111, 16'd100, 16'd3, 16'hFF9F, 1);
    run_op("zero",  2'd0, 6'b101010, 16'd100, 16'd3, 16'h0000, 1);
    run_op("x|y",   2'd0, 6'b010101, 16'd100, 16'd3, 16'd103,  1);

    // Mode 1, multiply
    run_op("mul",       2'd1, 6'b000000, 16'd100,   16'd3,     16'd300,  17);
    run_op("mul neg",   2'd1, 6'b000000, 16'hFFFE,  16'd3,     16'hFFFA, 17);
    run_op("mul trunc", 2'd1, 6'b000000, 16'h0100,  16'h0100,  16'h0000, 17);
    run_op("mul no",    2'd1, 6'b000001, 16'd100,   16'd3,     16'hFED3, 17);

    // Shifts
    run_op("sll 15",  2'd2, 6'b000000, 16'd1,     16'd15, 16'h8000, 1);
    run_op("sll 16",  2'd2, 6'b000000, 16'd1,     16'd16, 16'h0000, 1);
    run_op("srl 15",  2'd3, 6'b000000, 16'h8000,  16'd15, 16'h0001, 1);
    run_op("srl 4",   2'd3, 6'b000000, 16'hF000,  16'd4,  16'h0F00, 1);

    // Backpressure: result 97 held while new commands are offered
    @(negedge clk);
    drive_cmd(2'd0, 6'b010011, 16'd100, 16'd3);
    @(posedge clk);
    #1;
    check("bp first valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_cmd(2'd0, 6'b000010, 16'(i + 1), 16'(2 * i + 7));
      @(posedge clk);
      #1;
      check("bp out held", 32'(bus.out), 32'd97);
      check("bp valid held", 32'(bus.out_valid), 32'd1);
      check("bp in_ready low", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    drive_cmd(2'd0, 6'b000010, 16'd20, 16'd22);
    bus.out_ready = 1'b1;
    @(posedge clk);  // consume edge
    #1;
    check("bp release valid", 32'(bus.out_valid), 32'd0);
    check("bp release ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    @(posedge clk);  // pending command accepted here
    #1;
    bus.in_valid = 1'b0;
    check("bp pending valid", 32'(bus.out_valid), 32'd1);
    check("bp pending out", 32'(bus.out), 32'd42);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset for 2 cycles during an active multiply; out holds 42 beforehand
    @(negedge clk);
    drive_cmd(2'd1, 6'b000000, 16'd100, 16'd3);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst out", 32'(bus.out), 32'd0);
      check("rst zr", 32'(bus.zr), 32'd1);
      check("rst ng", 32'(bus.ng), 32'd0);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst release in_ready", 32'(bus.in_ready), 32'd1);

    // Reset mid-multiply at iteration 8: no result may appear
    @(negedge clk);
    drive_cmd(2'd1, 6'b000000, 16'd7, 16'd9);
    @(posedge clk);  // accept edge
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("aborted mul no valid", 32'(seen), 32'd0);
    run_op("mul after rst", 2'd1, 6'b000000, 16'd7, 16'd9, 16'd63, 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
